// File: rtl/tt_response_checker_pkg.sv
// Shared types and constants for the full-adder truth-table response checker.
// No logic: state encoding, table defaults, widths and an index decoder.
// Imported by the interface, the coverage tracker and the top level.
package tt_check_pkg;

   localparam int NUM_VEC = 8;
   localparam int IDX_W   = 3;
   localparam int CNT_W   = 4;

   // Default expected tables: x is the full-adder sum, y is the carry.
   localparam logic [NUM_VEC-1:0] EXP_X_DEF = 8'h96;
   localparam logic [NUM_VEC-1:0] EXP_Y_DEF = 8'hE8;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // One-hot decode of a vector index into a coverage mask.
   function automatic logic [NUM_VEC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_VEC-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/tt_response_checker_if.sv
// Stimulus/response handshake and result bus of the truth-table checker.
// master = the side presenting vectors and reading results; slave = checker.
// vec_valid/vec_ready: a beat transfers on a clock edge where both are high.
interface tt_check_if;
   import tt_check_pkg::*;

   logic                 start;
   logic                 vec_valid;
   logic                 vec_ready;
   logic                 p;
   logic                 q;
   logic                 r;
   logic                 x;
   logic                 y;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [CNT_W-1:0]     mismatch_count;
   logic [IDX_W-1:0]     first_fail_vec;
   logic                 first_fail_valid;
   logic [NUM_VEC-1:0]   covered;

   modport master (
      output start, vec_valid, p, q, r, x, y,
      input  vec_ready, busy, done, pass, mismatch_count,
             first_fail_vec, first_fail_valid, covered
   );

   modport slave (
      input  start, vec_valid, p, q, r, x, y,
      output vec_ready, busy, done, pass, mismatch_count,
             first_fail_vec, first_fail_valid, covered
   );

endinterface

// File: rtl/tt_response_checker_cov_tracker.sv
// Coverage mask, saturating mismatch counter and first-failure capture.
// Results update at the accepting edge, visible the following cycle.
// No backpressure of its own; the caller qualifies beats with acc_i.
module tt_cov_tracker
   import tt_check_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear_i,
   input  logic               acc_i,
   input  logic [IDX_W-1:0]   idx_i,
   input  logic               fail_i,
   output logic [NUM_VEC-1:0] covered_o,
   output logic [CNT_W-1:0]   mismatch_count_o,
   output logic [IDX_W-1:0]   first_fail_vec_o,
   output logic               first_fail_valid_o
);

   logic [NUM_VEC-1:0] covered_q, covered_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   ffv_q, ffv_d;
   logic               ffval_q, ffval_d;

   // Next-state: a start clears everything; an accepted beat marks coverage
   // and, if failing, bumps the count and latches only the first failing index.
   always_comb begin
      covered_d = covered_q;
      cnt_d     = cnt_q;
      ffv_d     = ffv_q;
      ffval_d   = ffval_q;
      if (clear_i) begin
         covered_d = '0;
         cnt_d     = '0;
         ffv_d     = '0;
         ffval_d   = 1'b0;
      end else if (acc_i) begin
         covered_d = covered_q | idx_onehot(idx_i);
         if (fail_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (!ffval_q) begin
               ffv_d   = idx_i;
               ffval_d = 1'b1;
            end
         end
      end
   end

   // Result registers; reset wins over any beat in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         covered_q <= '0;
         cnt_q     <= '0;
         ffv_q     <= '0;
         ffval_q   <= 1'b0;
      end else begin
         covered_q <= covered_d;
         cnt_q     <= cnt_d;
         ffv_q     <= ffv_d;
         ffval_q   <= ffval_d;
      end
   end

   assign covered_o          = covered_q;
   assign mismatch_count_o   = cnt_q;
   assign first_fail_vec_o   = ffv_q;
   assign first_fail_valid_o = ffval_q;

endmodule

// File: rtl/tt_response_checker.sv
// Checks a DUT's response to all 8 input vectors against expected x/y tables.
// One beat per cycle while running; results visible one cycle after the beat.
// vec_ready is high only in RUN; beats offered in IDLE/DONE are ignored.
module tt_response_checker
   import tt_check_pkg::*;
#(
   parameter logic [NUM_VEC-1:0] EXP_X = EXP_X_DEF,
   parameter logic [NUM_VEC-1:0] EXP_Y = EXP_Y_DEF
) (
   input  logic       clk,
   input  logic       reset,
   tt_check_if.slave  bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx;
   logic               accept;
   logic               fail;
   logic               clear;
   logic               all_cov;
   logic [NUM_VEC-1:0] covered;
   logic [CNT_W-1:0]   mismatch_count;

   assign idx     = {bus.p, bus.q, bus.r};
   assign accept  = bus.vec_valid && (state_q == S_RUN);
   assign fail    = (bus.x != EXP_X[idx]) || (bus.y != EXP_Y[idx]);
   // start is ignored while running; from IDLE or DONE it wipes prior results.
   assign clear   = bus.start && (state_q != S_RUN);
   assign all_cov = ((covered | idx_onehot(idx)) == '1);

   // Run control: leave RUN on the very beat that completes coverage.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (accept && all_cov) state_d = S_DONE;
         S_DONE:  if (bus.start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   tt_cov_tracker u_cov (
      .clk                (clk),
      .reset              (reset),
      .clear_i            (clear),
      .acc_i              (accept),
      .idx_i              (idx),
      .fail_i             (fail),
      .covered_o          (covered),
      .mismatch_count_o   (mismatch_count),
      .first_fail_vec_o   (bus.first_fail_vec),
      .first_fail_valid_o (bus.first_fail_valid)
   );

   assign bus.vec_ready      = (state_q == S_RUN);
   assign bus.busy           = (state_q == S_RUN);
   assign bus.done           = (state_q == S_DONE);
   assign bus.pass           = (state_q == S_DONE) && (mismatch_count == '0);
   assign bus.mismatch_count = mismatch_count;
   assign bus.covered        = covered;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: full-adder responses, injected
// faults, ordering/duplicates, saturation, mid-run reset and restart.
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_tt_response_checker;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   tt_check_if bus ();

   tt_response_checker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic fa_sum(input logic [2:0] i);
      return i[2] ^ i[1] ^ i[0];
   endfunction

   function automatic logic fa_carry(input logic [2:0] i);
      return (i[2] & i[1]) | (i[2] & i[0]) | (i[1] & i[0]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // Presents one beat for one cycle; flip_* corrupts the response bit.
   task automatic beat(input logic [2:0] idx, input logic flip_x, input logic flip_y);
      bus.vec_valid = 1'b1;
      {bus.p, bus.q, bus.r} = idx;
      bus.x = fa_sum(idx) ^ flip_x;
      bus.y = fa_carry(idx) ^ flip_y;
      step();
      bus.vec_valid = 1'b0;
   endtask

   task automatic chk_results(input string tag, input logic done, input logic pass,
                              input logic [3:0] mc, input logic [7:0] cov);
      chk({tag, "_done"}, 32'(bus.done), 32'(done));
      chk({tag, "_pass"}, 32'(bus.pass), 32'(pass));
      chk({tag, "_mc"},   32'(bus.mismatch_count), 32'(mc));
      chk({tag, "_cov"},  32'(bus.covered), 32'(cov));
   endtask

   task automatic chk_all_zero(input string tag);
      chk_results(tag, 1'b0, 1'b0, 4'd0, 8'h00);
      chk({tag, "_ready"}, 32'(bus.vec_ready), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy), 32'd0);
      chk({tag, "_ffv"},   32'(bus.first_fail_vec), 32'd0);
      chk({tag, "_ffval"}, 32'(bus.first_fail_valid), 32'd0);
   endtask

   initial begin
      logic [2:0] order [9];
      bus.start = 1'b0; bus.vec_valid = 1'b0;
      bus.p = 1'b0; bus.q = 1'b0; bus.r = 1'b0; bus.x = 1'b0; bus.y = 1'b0;

      // Reset state and beats ignored in IDLE.
      reset = 1'b1; step(); step(); reset = 1'b0;
      chk_all_zero("reset");
      beat(3'd2, 1'b0, 1'b0);
      chk("idle_ignore_cov", 32'(bus.covered), 32'h00);

      // Clean in-order run.
      pulse_start();
      chk("run_ready", 32'(bus.vec_ready), 32'd1);
      chk("run_busy",  32'(bus.busy), 32'd1);
      for (int i = 0; i < 7; i++) beat(3'(i), 1'b0, 1'b0);
      chk_results("clean7", 1'b0, 1'b0, 4'd0, 8'h7F);
      beat(3'd7, 1'b0, 1'b0);
      chk_results("clean8", 1'b1, 1'b1, 4'd0, 8'hFF);
      chk("clean8_ready", 32'(bus.vec_ready), 32'd0);
      chk("clean8_busy",  32'(bus.busy), 32'd0);
      chk("clean8_ffval", 32'(bus.first_fail_valid), 32'd0);
      // Results held in DONE; offered beat ignored.
      step(); step();
      beat(3'd5, 1'b1, 1'b0);
      chk_results("hold", 1'b1, 1'b1, 4'd0, 8'hFF);

      // Restart from DONE clears at once; idx 5 returns x=1,y=1.
      pulse_start();
      chk_results("restart", 1'b0, 1'b0, 4'd0, 8'h00);
      chk("restart_ready", 32'(bus.vec_ready), 32'd1);
      for (int i = 0; i < 8; i++) beat(3'(i), (i == 5), 1'b0);
      chk_results("fail5", 1'b1, 1'b0, 4'd1, 8'hFF);
      chk("fail5_ffv",   32'(bus.first_fail_vec), 32'd5);
      chk("fail5_ffval", 32'(bus.first_fail_valid), 32'd1);

      // Out-of-order with duplicate and gaps; start during RUN ignored.
      order = '{3'd7, 3'd7, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         beat(order[i], 1'b0, 1'b0);
         if (i == 1) chk_results("dup7", 1'b0, 1'b0, 4'd0, 8'h80);
         if (i == 2) begin
            pulse_start();
            chk_results("start_in_run", 1'b0, 1'b0, 4'd0, 8'h88);
            chk("start_in_run_busy", 32'(bus.busy), 32'd1);
         end
         if (i == 7) chk_results("before6", 1'b0, 1'b0, 4'd0, 8'hBF);
         if (i < 8) begin step(); step(); end
      end
      chk_results("order", 1'b1, 1'b1, 4'd0, 8'hFF);

      // Saturation: 20 failing idx-0 beats, then first failure is idx 1 region clean.
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         beat(3'd0, 1'b1, 1'b0);
         if (i == 13) chk("sat14", 32'(bus.mismatch_count), 32'd14);
         if (i == 14) chk("sat15", 32'(bus.mismatch_count), 32'd15);
      end
      chk("sat20", 32'(bus.mismatch_count), 32'd15);
      beat(3'd3, 1'b0, 1'b1);
      chk("sat_ffv_keep", 32'(bus.first_fail_vec), 32'd0);
      for (int i = 1; i < 8; i++) beat(3'(i), 1'b0, 1'b0);
      chk_results("sat_end", 1'b1, 1'b0, 4'd15, 8'hFF);
      chk("sat_ffval", 32'(bus.first_fail_valid), 32'd1);

      // Mid-run reset: beat in the reset cycle is dropped.
      pulse_start();
      beat(3'd0, 1'b0, 1'b0);
      beat(3'd1, 1'b1, 1'b0);
      beat(3'd2, 1'b0, 1'b0);
      beat(3'd3, 1'b0, 1'b0);
      chk_results("mid4", 1'b0, 1'b0, 4'd1, 8'h0F);
      reset = 1'b1;
      beat(3'd4, 1'b1, 1'b1);
      reset = 1'b0;
      chk_all_zero("midreset");
      beat(3'd4, 1'b0, 1'b0);
      chk("post_reset_ignore", 32'(bus.covered), 32'h00);
      pulse_start();
      for (int i = 7; i >= 0; i--) beat(3'(i), 1'b0, 1'b0);
      chk_results("rerun", 1'b1, 1'b1, 4'd0, 8'hFF);
      chk("rerun_ffval", 32'(bus.first_fail_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tt_response_checker.md
TT_RESPONSE_CHECKER -- requirements
Module: tt_response_checker

Interface
REQ-001 Parameter EXP_X, default 8'h96, expected x per vector; bit i is the expected value for vector index i = {p,q,r} (full-adder sum).
REQ-002 Parameter EXP_Y, default 8'hE8, expected y per vector, same indexing (full-adder carry).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins a check run.
REQ-006 vec_valid  in  1  a stimulus vector and its DUT response are present.
REQ-007 vec_ready  out  1  checker accepts a vector this cycle.
REQ-008 p, q, r  in  1 each  stimulus vector; index = {p,q,r}.
REQ-009 x, y  in  1 each  DUT response to the stimulus vector.
REQ-010 busy  out  1  run in progress.
REQ-011 done  out  1  all 8 vectors covered; held until the next start or reset.
REQ-012 pass  out  1  valid while done; 1 iff mismatch_count == 0.
REQ-013 mismatch_count  out  4  number of failing accepted beats, saturating at 15.
REQ-014 first_fail_vec  out  3  index of the first failing beat.
REQ-015 first_fail_valid  out  1  first_fail_vec holds a valid index.
REQ-016 covered  out  8  bit i set once vector index i has been accepted.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE. Transitions: IDLE -start-> RUN; RUN -all covered-> DONE; DONE -start-> RUN.
REQ-018 On entry to RUN from start, covered, mismatch_count, first_fail_valid, first_fail_vec and done SHALL be cleared at the same edge.
REQ-019 vec_ready SHALL be 1 only in RUN; busy SHALL be 1 only in RUN.
REQ-020 A beat is accepted on a rising edge where vec_valid && vec_ready; vec_valid outside RUN SHALL be ignored.
REQ-021 A beat fails if x != EXP_X[idx] or y != EXP_Y[idx]; each failing beat increments mismatch_count by 1, saturating at 15.
REQ-022 On the first failing beat of a run, first_fail_vec <= idx and first_fail_valid <= 1; later failures SHALL NOT change first_fail_vec.
REQ-023 covered[idx] SHALL be set at the accepting edge, so counters and coverage are visible the cycle after acceptance.
REQ-024 Duplicate indices SHALL be re-checked and counted again, with covered unchanged.
REQ-025 When the accepted beat completes covered == 8'hFF, the FSM SHALL enter DONE at that same edge: done=1 and vec_ready=0 in the next cycle.
REQ-026 pass SHALL be 0 whenever done is 0.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 start coincident with an accepted beat in DONE is not possible, since vec_ready=0 in DONE.
REQ-029 Results SHALL be held in DONE until start or reset.

Reset
REQ-030 Reset SHALL take priority over start and vec_valid.
REQ-031 On reset, the state SHALL go to IDLE and all outputs SHALL be 0: vec_ready, busy, done, pass, mismatch_count=0, first_fail_vec=0, first_fail_valid, covered=8'h00.
REQ-032 Reset mid-RUN SHALL discard all partial results; the beat presented in the reset cycle SHALL NOT be counted.

Structure
REQ-033 Package tt_check_pkg SHALL hold the state enum (IDLE, RUN, DONE), NUM_VEC=8, IDX_W=3, CNT_W=4, and the default tables 8'h96 and 8'hE8.
REQ-034 The block SHALL contain one sub-module, tt_cov_tracker, which holds the coverage register, the saturating mismatch counter and the first-fail capture; the FSM stays in the top level.

Verification
REQ-035 Run with defaults: reset, start, then 8 beats in order 0..7 carrying a correct full-adder response -> done=1 one cycle after the 8th beat, pass=1, mismatch_count=0, covered=8'hFF.
REQ-036 Same run, but the beat for idx 5 returns x=1, y=1 (expected 0,1) -> mismatch_count=1, first_fail_vec=5, first_fail_valid=1, pass=0.
REQ-037 Ordering and duplicates: beats 7,7,3,0,1,2,4,5,6 all correct, with vec_valid low for 2 cycles between beats -> done only after idx 6 is accepted, covered=8'hFF, mismatch_count=0.
REQ-038 Saturation: 20 failing beats of idx 0, then idx 1..7 correct -> mismatch_count=15, first_fail_vec=0, done=1, pass=0.
REQ-039 Reset mid-run after 4 beats -> all outputs 0, IDLE; a beat presented after reset is ignored until start; a new full run passes.
REQ-040 start pulsed during RUN -> covered and counters are unchanged; start in DONE -> everything clears and RUN is re-entered with vec_ready=1 the next cycle.
